// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the single register-file write port between the
// writeback stage and a small in-order FIFO of long-latency results.
// Writeback writes pass straight through. Buffered results drain into idle port
// cycles, or steal the port with a one-cycle stall once the head has starved.
module rf_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned DEPTH        = 2
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iWbWrite,
  input  logic [4:0]  iWbAddr,
  input  logic [31:0] iWbData,
  input  logic        iLuValid,
  input  logic [4:0]  iLuAddr,
  input  logic [31:0] iLuData,
  output logic        oLuReady,
  input  logic [4:0]  iCheckAddr,
  output logic        oCheckHit,
  output logic        oStall,
  output logic        oRfWrite,
  output logic [4:0]  oRfAddr,
  output logic [31:0] oRfData
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = 4;
  localparam int unsigned RW = 5;
  localparam int unsigned DW = 32;

  // FIFO storage; a slot's live bit is only ever set while that slot is occupied
  logic [RW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [DEPTH-1:0] r_live;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [SW-1:0]    r_starve;

  logic          w_wbv;
  logic          w_empty;
  logic          w_head_live;
  logic          w_head_dead;
  logic          w_starved;
  logic          w_sel_head;
  logic          w_stall;
  logic          w_grant_wb;
  logic          w_pop;
  logic          w_ready;
  logic          w_keep;
  logic          w_hit_stored;
  logic [CW-1:0] w_count_nxt;
  logic [SW-1:0] w_starve_nxt;

  // Port selection, FIFO push/pop decisions and starvation counter update
  always_comb begin
    w_wbv       = iWbWrite & (iWbAddr != RW'(0));
    w_empty     = (r_count == CW'(0));
    w_head_live = ~w_empty & r_live[r_rd_ptr];
    w_head_dead = ~w_empty & ~r_live[r_rd_ptr];
    w_starved   = (r_starve >= SW'(STARVE_LIMIT));

    // The head takes the port when it is idle, or when the head has starved
    w_sel_head  = w_head_live & (~w_wbv | w_starved);
    w_stall     = w_head_live & w_wbv & w_starved;
    w_grant_wb  = w_wbv & ~w_stall;
    w_pop       = w_sel_head | w_head_dead;

    // Results older than a same-address writeback are already stale: drop them
    w_ready     = iReset_n & (r_count < CW'(DEPTH));
    w_keep      = iLuValid & w_ready & (iLuAddr != RW'(0)) &
                  ~(iWbWrite & (iWbAddr == iLuAddr));

    w_count_nxt = r_count + CW'(w_keep) - CW'(w_pop);

    w_starve_nxt = r_starve;
    if (w_sel_head) begin
      w_starve_nxt = SW'(0);
    end else if (w_head_live && w_wbv && (r_starve != {SW{1'b1}})) begin
      w_starve_nxt = r_starve + SW'(1);
    end
    if (w_count_nxt == CW'(0)) begin
      w_starve_nxt = SW'(0);
    end
  end

  // Decode-stage hazard lookup over live buffered entries
  always_comb begin
    w_hit_stored = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (r_live[i] && (r_addr[i] == iCheckAddr)) begin
        w_hit_stored = 1'b1;
      end
    end
  end

  // Combinational outputs, forced to zero while reset is asserted
  always_comb begin
    oLuReady  = w_ready;
    oStall    = 1'b0;
    oCheckHit = 1'b0;
    oRfWrite  = 1'b0;
    oRfAddr   = RW'(0);
    oRfData   = DW'(0);
    if (iReset_n) begin
      oStall    = w_stall;
      oCheckHit = (iCheckAddr != RW'(0)) &
                  (w_hit_stored | (w_keep & (iLuAddr == iCheckAddr)));
      if (w_sel_head) begin
        oRfWrite = 1'b1;
        oRfAddr  = r_addr[r_rd_ptr];
        oRfData  = r_data[r_rd_ptr];
      end else if (w_grant_wb) begin
        oRfWrite = 1'b1;
        oRfAddr  = iWbAddr;
        oRfData  = iWbData;
      end
    end
  end

  // FIFO control state: pointers, occupancy, live bits and starvation counter
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_rd_ptr <= AW'(0);
      r_wr_ptr <= AW'(0);
      r_count  <= CW'(0);
      r_starve <= SW'(0);
      r_live   <= '0;
    end else begin
      // A granted writeback supersedes every buffered write to the same register
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (w_grant_wb && (r_addr[i] == iWbAddr)) begin
          r_live[i] <= 1'b0;
        end
      end
      if (w_pop) begin
        r_live[r_rd_ptr] <= 1'b0;
        r_rd_ptr         <= r_rd_ptr + AW'(1);
      end
      if (w_keep) begin
        r_live[r_wr_ptr] <= 1'b1;
        r_wr_ptr         <= r_wr_ptr + AW'(1);
      end
      r_count  <= w_count_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  // FIFO payload; qualified by r_live so it needs no reset
  always_ff @(posedge iClk) begin
    if (w_keep) begin
      r_addr[r_wr_ptr] <= iLuAddr;
      r_data[r_wr_ptr] <= iLuData;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed scenarios followed by random traffic. A queue
// based reference model predicts each cycle's outputs; a monitor process pops
// and compares them, and also tracks the register file the DUT builds.
module tb_rf_write_arbiter;

  localparam int unsigned LIMIT = 4;
  localparam int unsigned DEPTH = 2;

  logic        iClk = 1'b0;
  logic        iReset_n = 1'b0;
  logic        iWbWrite = 1'b0;
  logic [4:0]  iWbAddr = '0;
  logic [31:0] iWbData = '0;
  logic        iLuValid = 1'b0;
  logic [4:0]  iLuAddr = '0;
  logic [31:0] iLuData = '0;
  logic        oLuReady;
  logic [4:0]  iCheckAddr = '0;
  logic        oCheckHit;
  logic        oStall;
  logic        oRfWrite;
  logic [4:0]  oRfAddr;
  logic [31:0] oRfData;

  rf_write_arbiter #(.STARVE_LIMIT(LIMIT), .DEPTH(DEPTH)) dut (
    .iClk(iClk), .iReset_n(iReset_n),
    .iWbWrite(iWbWrite), .iWbAddr(iWbAddr), .iWbData(iWbData),
    .iLuValid(iLuValid), .iLuAddr(iLuAddr), .iLuData(iLuData),
    .oLuReady(oLuReady), .iCheckAddr(iCheckAddr), .oCheckHit(oCheckHit),
    .oStall(oStall), .oRfWrite(oRfWrite), .oRfAddr(oRfAddr), .oRfData(oRfData)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    bit          live;
  } ent_t;

  typedef struct {
    bit          rst;
    bit          wr;
    bit          stall;
    bit          ready;
    bit          hit;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  ent_t        mq[$];
  exp_t        cq[$];
  int          mcnt = 0;
  bit          m_last_stall = 0;
  logic [31:0] m_rf [32];
  logic [31:0] d_rf [32];
  int          checks = 0;
  int          errors = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endfunction

  function automatic bit live_match(input logic [4:0] a);
    foreach (mq[i]) if (mq[i].live && mq[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one cycle of inputs and advance the reference model
  task automatic cycle(input bit rst, input bit wbw, input logic [4:0] wba,
                       input logic [31:0] wbd, input bit luv, input logic [4:0] lua,
                       input logic [31:0] lud, input logic [4:0] ck, output bit acc);
    exp_t e;
    bit wbv, head_live, pop, keep;
    @(negedge iClk);
    iReset_n = rst; iWbWrite = wbw; iWbAddr = wba; iWbData = wbd;
    iLuValid = luv; iLuAddr = lua; iLuData = lud; iCheckAddr = ck;
    e = '{rst: !rst, wr: 0, stall: 0, ready: 0, hit: 0, addr: '0, data: '0};
    acc = 0;
    if (!rst) begin
      mq.delete();
      mcnt = 0;
      m_last_stall = 0;
      cq.push_back(e);
      return;
    end
    wbv       = wbw && (wba != 5'd0);
    e.ready   = (mq.size() < int'(DEPTH));
    head_live = (mq.size() > 0) && mq[0].live;
    pop       = (mq.size() > 0) && !mq[0].live;
    if (head_live && (!wbv || mcnt == int'(LIMIT))) begin
      e.wr = 1; e.addr = mq[0].addr; e.data = mq[0].data;
      e.stall = wbv; pop = 1; mcnt = 0;
    end else begin
      if (wbv) begin e.wr = 1; e.addr = wba; e.data = wbd; end
      if (head_live) mcnt++;
    end
    keep  = luv && e.ready && (lua != 5'd0) && !(wbw && wba == lua);
    acc   = luv && e.ready;
    e.hit = (ck != 5'd0) && ((keep && lua == ck) || live_match(ck));
    if (wbv && !e.stall) foreach (mq[i]) if (mq[i].addr == wba) mq[i].live = 0;
    if (pop) void'(mq.pop_front());
    if (keep) mq.push_back('{addr: lua, data: lud, live: 1'b1});
    if (mq.size() == 0) mcnt = 0;
    if (e.wr) m_rf[e.addr] = e.data;
    m_last_stall = e.stall;
    cq.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the predicted record for this cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge iClk);
      #2;
      if (cq.size() != 0) begin
        e = cq.pop_front();
        chk("lu_ready", 32'(oLuReady), 32'(e.ready));
        chk("stall", 32'(oStall), 32'(e.stall));
        chk("check_hit", 32'(oCheckHit), 32'(e.hit));
        chk("rf_write", 32'(oRfWrite), 32'(e.wr));
        if (e.wr || e.rst) begin
          chk("rf_addr", 32'(oRfAddr), 32'(e.addr));
          chk("rf_data", oRfData, e.data);
        end
        if (oRfWrite) d_rf[oRfAddr] = oRfData;
      end
    end
  end

  initial begin
    bit acc;
    bit rw, rl, rs;
    logic [4:0] ra, la, ck;
    logic [31:0] rd, ld;
    int n;
    for (int i = 0; i < 32; i++) begin m_rf[i] = '0; d_rf[i] = '0; end

    // Reset state, even with writeback requests present
    cycle(0, 1, 5'd5, 32'h55, 1, 5'd6, 32'h66, 5'd6, acc);
    cycle(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, acc);

    // Pass-through and suppressed write to r0
    cycle(1, 1, 5'd5, 32'h1234, 0, 5'd0, 32'h0, 5'd0, acc);
    cycle(1, 1, 5'd0, 32'hDEAD, 0, 5'd0, 32'h0, 5'd0, acc);

    // Idle-cycle drain with hazard lookup
    cycle(1, 0, 5'd0, 32'h0, 1, 5'd7, 32'hAAAA, 5'd7, acc);
    for (int i = 0; i < 3; i++) cycle(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd7, acc);

    // Starvation: continuous writebacks to r10 hold off the r9 result
    cycle(1, 0, 5'd0, 32'h0, 1, 5'd9, 32'h9999, 5'd9, acc);
    for (int i = 0; i < 8; i++) cycle(1, 1, 5'd10, 32'h10A0, 0, 5'd0, 32'h0, 5'd9, acc);

    // Write-after-write: younger writeback kills the buffered r3 result
    cycle(1, 0, 5'd0, 32'h0, 1, 5'd3, 32'h1, 5'd3, acc);
    cycle(1, 1, 5'd3, 32'h2, 0, 5'd0, 32'h0, 5'd3, acc);
    for (int i = 0; i < 3; i++) cycle(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd3, acc);

    // Same-cycle push and writeback to one register: push is dropped
    cycle(1, 1, 5'd4, 32'h44, 1, 5'd4, 32'h4444, 5'd4, acc);
    cycle(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd4, acc);

    // Full FIFO under continuous writebacks; third result waits for space
    cycle(1, 1, 5'd10, 32'hB0, 1, 5'd11, 32'hB11, 5'd11, acc);
    cycle(1, 1, 5'd10, 32'hB1, 1, 5'd12, 32'hB12, 5'd12, acc);
    n = 0;
    do begin
      cycle(1, 1, 5'd10, 32'hB2, 1, 5'd13, 32'hB13, 5'd13, acc);
      n++;
    end while (!acc && n < 30);
    chk("full_wait_bound", 32'(acc), 32'd1);
    for (int i = 0; i < 12; i++) cycle(1, (i % 2) == 0, 5'd10, 32'hB3, 0, 5'd0, 32'h0, 5'd12, acc);

    // Reset with two entries buffered; nothing of them may be written later
    cycle(1, 1, 5'd10, 32'hC0, 1, 5'd14, 32'hC14, 5'd14, acc);
    cycle(1, 1, 5'd10, 32'hC1, 1, 5'd15, 32'hC15, 5'd15, acc);
    cycle(0, 1, 5'd10, 32'hC2, 0, 5'd0, 32'h0, 5'd14, acc);
    cycle(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd15, acc);
    for (int i = 0; i < 4; i++) cycle(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd14, acc);

    // Random traffic; writeback inputs are held across a stall like the pipeline does
    rw = 0; ra = '0; rd = '0;
    for (int k = 0; k < 3000; k++) begin
      if (!m_last_stall) begin
        rw = ($urandom_range(3, 0) != 0);
        ra = 5'($urandom_range(7, 0));
        rd = $urandom;
      end
      rl = ($urandom_range(2, 0) == 0);
      la = 5'($urandom_range(7, 0));
      ld = $urandom;
      ck = 5'($urandom_range(7, 0));
      rs = ($urandom_range(299, 0) != 0);
      cycle(rs, rw, ra, rd, rl, la, ld, ck, acc);
    end
    for (int i = 0; i < 4; i++) cycle(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, acc);

    @(negedge iClk);
    #3;
    for (int i = 1; i < 32; i++) chk($sformatf("rf_r%0d", i), d_rf[i], m_rf[i]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
